display_scan_mux: RTL

- Parametrised successor to the single-digit 7-segment decoder used by the voting-machine (urna) front panel.
- Drives N_DIGITS time-multiplexed common-anode digits from one shared segment bus.
- Adds a latched shadow register, a scan counter, per-digit blink, global blanking and optional leading-zero suppression.
- Sits between the vote/candidate-number logic and the board display pins.

---
 rtl/display_scan_mux.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/display_scan_mux.sv
// display_scan_mux: time-multiplexed 7-segment scanner with shadow register,
// per-digit blink, global blanking and leading-zero suppression.
module display_scan_mux #(
    parameter int N_DIGITS     = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 64,
    parameter int LZ_BLANK     = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*N_DIGITS-1:0]   digits_in,
    input  logic                    load,
    input  logic [N_DIGITS-1:0]     blink_en,
    input  logic                    blank_all,
    output logic [6:0]              seg,
    output logic [N_DIGITS-1:0]     an,
    output logic                    frame_tick
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(N_DIGITS);
    localparam int FW = $clog2(BLINK_FRAMES + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);
    localparam logic [FW-1:0] FR_LAST  = FW'(BLINK_FRAMES - 1);
    localparam logic [N_DIGITS-1:0] AN_ONE = {{(N_DIGITS-1){1'b0}}, 1'b1};

    logic [4*N_DIGITS-1:0] shadow_q, shadow_d;
    logic [DW-1:0]         div_q, div_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [FW-1:0]         cnt_q, cnt_d;
    logic                  phase_q, phase_d;
    logic [6:0]            seg_q, seg_d;
    logic [N_DIGITS-1:0]   an_q, an_d;
    logic                  tick_q, tick_d;

    logic                  adv;
    logic [N_DIGITS-1:0]   lz_mask;
    logic                  lz_run;
    logic [3:0]            cur_code;
    logic                  cur_blink;
    logic                  cur_lz;
    logic                  cur_blank;

    function automatic logic [6:0] decode(input logic [3:0] c);
        logic [6:0] s;
        case (c)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hD:    s = 7'b1110111;
            4'hE:    s = 7'b0111111;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    assign adv = (div_q == DIV_LAST);

    // Leading-zero run: zeros from the top digit down, digit 0 never included
    always_comb begin
        lz_mask = '0;
        lz_run  = 1'b1;
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            lz_run     = lz_run & (shadow_q[4*i +: 4] == 4'h0);
            lz_mask[i] = lz_run;
        end
    end

    // Pick code and per-digit attributes for the digit about to be issued
    always_comb begin
        cur_code  = 4'hF;
        cur_blink = 1'b0;
        cur_lz    = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                cur_code  = shadow_q[4*i +: 4];
                cur_blink = blink_en[i];
                cur_lz    = lz_mask[i];
            end
        end
        cur_blank = blank_all
                  | (cur_blink & ~phase_q)
                  | ((LZ_BLANK != 0) & cur_lz);
    end

    // Next-state: divider, scan index, frame/blink counters, output slot
    always_comb begin
        shadow_d = load ? digits_in : shadow_q;
        div_d    = adv ? '0 : div_q + 1'b1;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        phase_d  = phase_q;
        seg_d    = seg_q;
        an_d     = an_q;
        tick_d   = 1'b0;
        if (adv) begin
            an_d  = ~(AN_ONE << idx_q);
            seg_d = cur_blank ? 7'b1111111 : decode(cur_code);
            if (idx_q == IDX_LAST) begin
                idx_d  = '0;
                tick_d = 1'b1;
                if (cnt_q == FR_LAST) begin
                    cnt_d   = '0;
                    phase_d = ~phase_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    // State registers; reset blanks the display and restarts the scan
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q <= '1;
            div_q    <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            phase_q  <= 1'b1;
            seg_q    <= 7'b1111111;
            an_q     <= '1;
            tick_q   <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            div_q    <= div_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
            seg_q    <= seg_d;
            an_q     <= an_d;
            tick_q   <= tick_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_tick = tick_q;

endmodule
